// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and instruction-word constants.
package cpu_pkg;

  localparam int unsigned INST_W = 16;
  localparam logic [INST_W-1:0] BUBBLE_INST = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with instruction memory, absorbs decode
// back-pressure in a one-entry skid buffer and flushes the stream on execute redirects.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   pc_plus1
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [INST_W-1:0] skid_q, skid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_d       = skid_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    imem_req     = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          inst_valid_d = 1'b0;
          if (imem_valid) begin
            pc_d = redirect_pc;
          end else begin
            // The old request is still outstanding; park the target until it completes.
            tgt_d   = redirect_pc;
            state_d = DRAIN;
          end
        end else if (imem_valid) begin
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + PC_ONE;
          end
        end else if (!stall) begin
          inst_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_d       = BUBBLE_INST;
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!stall) begin
          inst_d       = skid_q;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + PC_ONE;
          state_d      = FETCH;
        end
      end

      DRAIN: begin
        imem_req     = 1'b1;
        inst_valid_d = 1'b0;
        if (redirect) tgt_d = redirect_pc;
        if (imem_valid) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      skid_q       <= BUBBLE_INST;
      inst_q       <= BUBBLE_INST;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_q       <= skid_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus1   = inst_pc_q + PC_ONE;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against
// a stream-level model (program order, redirect targets, hold-under-stall, address stability).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic [15:0] pc_plus1;

  int errors = 0;
  int checks = 0;

  logic mem_auto;
  bit   mem_rand;
  int   mem_lat;
  int   mem_wait;

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .pc_plus1   (pc_plus1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h5A00 + a;
  endfunction

  function automatic int next_lat();
    return mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
  endfunction

  task automatic mem_drive();
    if (mem_auto) begin
      imem_valid = imem_req && (mem_wait == 0);
      imem_rdata = imem_valid ? mem_word(imem_addr) : 16'hDEAD;
    end
  endtask

  // One clock: advance the memory model, then present its response for the new cycle.
  task automatic tick();
    logic hs, rq;
    hs = imem_req & imem_valid;
    rq = imem_req;
    @(posedge clk);
    #1;
    if (hs) mem_wait = next_lat();
    else if (rq && mem_wait > 0) mem_wait--;
    mem_drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0; mem_auto = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_wait = next_lat();
    mem_drive();
  endtask

  task automatic expect_out(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    mem_rand = 0; mem_lat = 0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0; mem_auto = 1'b1;
    @(posedge clk); #1;
    expect_out("rst_req",      16'(imem_req),   16'h0);
    expect_out("rst_inst",     inst,            16'h0000);
    expect_out("rst_valid",    16'(inst_valid), 16'h0);
    expect_out("rst_inst_pc",  inst_pc,         16'h0000);
    expect_out("rst_pc_plus1", pc_plus1,        16'h0001);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_wait = 0; mem_drive();
    expect_out("idle_req", 16'(imem_req), 16'h0);
    tick();
    expect_out("first_req",  16'(imem_req), 16'h1);
    expect_out("first_addr", imem_addr,     16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("stream_valid", 16'(inst_valid), 16'h1);
      expect_out("stream_pc",    inst_pc,         16'(i));
      expect_out("stream_inst",  inst,            16'h5A00 + 16'(i));
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    n = 0;
    while (imem_addr !== 16'h0005 && n < 20) begin tick(); n++; end
    expect_out("stall_reach_addr5", imem_addr, 16'h0005);
    mem_auto = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h1234; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_valid = 1'b0;
      expect_out("stall_hold_inst",  inst,            16'h5A04);
      expect_out("stall_hold_pc",    inst_pc,         16'h0004);
      expect_out("stall_hold_valid", 16'(inst_valid), 16'h1);
      expect_out("stall_hold_req",   16'(imem_req),   16'h0);
    end
    stall = 1'b0;
    tick();
    expect_out("skid_inst",  inst,            16'h1234);
    expect_out("skid_pc",    inst_pc,         16'h0005);
    expect_out("skid_valid", 16'(inst_valid), 16'h1);
    expect_out("skid_next_addr", imem_addr,   16'h0006);
    mem_auto = 1'b1; mem_wait = 0; mem_drive();
    tick();
    expect_out("after_skid_inst", inst, 16'h5A06);
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    expect_out("redir_flush_valid", 16'(inst_valid), 16'h0);
    expect_out("redir_addr",        imem_addr,       16'h0040);
    tick();
    expect_out("redir_target_inst", inst,    16'h5A40);
    expect_out("redir_target_pc",   inst_pc, 16'h0040);
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    expect_out("wrap_addr_fffe", imem_addr, 16'hFFFE);
    tick();
    expect_out("wrap_pc_fffe", inst_pc,   16'hFFFE);
    expect_out("wrap_addr_ffff", imem_addr, 16'hFFFF);
    tick();
    expect_out("wrap_pc_ffff",  inst_pc,  16'hFFFF);
    expect_out("wrap_pc_plus1", pc_plus1, 16'h0000);
    expect_out("wrap_next_addr", imem_addr, 16'h0000);
    tick();
    expect_out("wrap_inst_0", inst, 16'h5A00);
  endtask

  task automatic test_drain();
    int n;
    mem_rand = 0; mem_lat = 3;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    expect_out("drain_addr_held1", imem_addr,       16'h0000);
    expect_out("drain_req1",       16'(imem_req),   16'h1);
    expect_out("drain_valid_low",  16'(inst_valid), 16'h0);
    redirect_pc = 16'h0090;
    tick();
    redirect = 1'b0;
    expect_out("drain_addr_held2", imem_addr, 16'h0000);
    tick();
    expect_out("drain_addr_held3", imem_addr, 16'h0000);
    tick();
    expect_out("drain_new_addr", imem_addr,       16'h0090);
    expect_out("drain_new_req",  16'(imem_req),   16'h1);
    expect_out("drain_no_inst",  16'(inst_valid), 16'h0);
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin tick(); n++; end
    expect_out("drain_target_pc",   inst_pc, 16'h0090);
    expect_out("drain_target_inst", inst,    16'h5A90);
    mem_lat = 0;
  endtask

  task automatic test_reset_in_hold();
    mem_rand = 0; mem_lat = 0;
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    tick();
    expect_out("hold_req", 16'(imem_req), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst_req",   16'(imem_req),   16'h0);
    expect_out("async_rst_inst",  inst,            16'h0000);
    expect_out("async_rst_valid", 16'(inst_valid), 16'h0);
    expect_out("async_rst_pc",    inst_pc,         16'h0000);
    stall = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mem_wait = 0; mem_drive();
    expect_out("restart_idle_req", 16'(imem_req), 16'h0);
    tick();
    expect_out("restart_addr", imem_addr, 16'h0000);
    tick();
    expect_out("restart_inst", inst,    16'h5A00);
    expect_out("restart_pc",   inst_pc, 16'h0000);
  endtask

  // Stream-level model: each delivered instruction continues program order from the last
  // delivery or the most recent redirect target; nothing is ever presented twice or lost.
  task automatic test_random();
    logic [15:0] exp_next, p_inst, p_pc, p_rpc, p_addr;
    logic        p_st, p_rd, p_req, p_val, p_iv, discard, hs_disc;
    int          accepted;
    mem_rand = 1;
    do_reset();
    exp_next = 16'h0000; discard = 1'b0; accepted = 0;
    for (int c = 0; c < 1500; c++) begin
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                 : 16'($urandom);
      p_st = stall; p_rd = redirect; p_rpc = redirect_pc;
      p_req = imem_req; p_val = imem_valid; p_addr = imem_addr;
      p_inst = inst; p_pc = inst_pc; p_iv = inst_valid;
      tick();
      hs_disc = p_req && p_val && discard;
      if (p_req && p_val) discard = 1'b0;
      if (p_rd && p_req && !p_val) discard = 1'b1;

      expect_out("rnd_pc_plus1", pc_plus1, inst_pc + 16'h1);
      if (p_rd) begin
        exp_next = p_rpc;
        expect_out("rnd_redir_flush", 16'(inst_valid), 16'h0);
        if (!(p_req && !p_val)) begin
          expect_out("rnd_redir_req",  16'(imem_req), 16'h1);
          expect_out("rnd_redir_addr", imem_addr,     p_rpc);
        end
      end else if (p_st) begin
        expect_out("rnd_stall_inst",  inst,            p_inst);
        expect_out("rnd_stall_pc",    inst_pc,         p_pc);
        expect_out("rnd_stall_valid", 16'(inst_valid), 16'(p_iv));
      end else begin
        if (p_req && p_val && !hs_disc)
          expect_out("rnd_deliver", 16'(inst_valid), 16'h1);
        if (inst_valid === 1'b1) begin
          expect_out("rnd_order", inst_pc, exp_next);
          expect_out("rnd_data",  inst,    mem_word(inst_pc));
          exp_next = inst_pc + 16'h1;
          accepted++;
        end
        if (hs_disc) begin
          expect_out("rnd_drain_req",  16'(imem_req), 16'h1);
          expect_out("rnd_drain_addr", imem_addr,     exp_next);
        end
      end
      if (p_req && !p_val) begin
        expect_out("rnd_addr_stable_req", 16'(imem_req), 16'h1);
        expect_out("rnd_addr_stable",     imem_addr,     p_addr);
      end
    end
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (accepted < 100) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d instructions want at least 100", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_drain();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter, issues word-addressed requests to instruction memory with a request/valid handshake, and presents one instruction per cycle to decode as inst / inst_valid. It absorbs decode back-pressure with a one-entry skid buffer and services branch/jump redirects from execute, including discarding a response that is still in flight.

## Interface
- PC_W, 16: PC and instruction-memory word-address width.
- RESET_PC, 16'h0000: first fetch address after reset.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; imem_addr is held stable while high until imem_valid.
- imem_addr  output  PC_W  word address being fetched.
- imem_rdata  input  16  instruction word; meaningful only when imem_valid.
- imem_valid  input  1  imem_rdata holds the word for the current imem_addr; may be high in the same cycle as imem_req.
- stall  input  1  decode cannot accept; inst, inst_valid, inst_pc hold.
- redirect  input  1  taken branch/jump from execute; flushes the fetch stream.
- redirect_pc  input  PC_W  new fetch address, sampled when redirect is high.
- inst  output  16  instruction register driving the decoder.
- inst_valid  output  1  inst is live; consumers qualify rf_we and mem with it.
- inst_pc  output  PC_W  address of inst.
- pc_plus1  output  PC_W  inst_pc + 1, modulo 2^PC_W, used as the JAL link value.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Registers: pc, tgt, skid, inst, inst_valid, inst_pc.
- IDLE: imem_req=0. Moves to FETCH on the next edge unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - valid & !stall & !redirect: inst<=rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+1. Stay in FETCH.
  - valid & stall & !redirect: skid<=rdata. inst and inst_valid hold. Go to HOLD.
  - !valid & !stall & !redirect: inst_valid<=0 (bubble).
  - !valid & stall: inst and inst_valid hold.
  - redirect & valid: discard rdata, pc<=redirect_pc, inst_valid<=0. Stay in FETCH.
  - redirect & !valid: tgt<=redirect_pc, inst_valid<=0. Go to DRAIN.
- HOLD: imem_req=0.
  - !stall & !redirect: inst<=skid, inst_pc<=pc, inst_valid<=1, pc<=pc+1. Go to FETCH.
  - redirect: drop skid, pc<=redirect_pc, inst_valid<=0. Go to FETCH.
- DRAIN: imem_req=1, imem_addr=pc (old address, held stable).
  - valid: discard rdata, pc<=tgt. Go to FETCH.
  - redirect: tgt<=redirect_pc; the newest redirect wins.
  - inst_valid stays 0 throughout DRAIN.
- Priority: redirect overrides stall. A redirect clears inst_valid even while stall is high.
- pc increments wrap: 16'hFFFF + 1 gives 16'h0000. pc_plus1 is combinational from inst_pc.

## Timing
- Reset (asynchronous, any state): state=IDLE, pc=RESET_PC, tgt=0, skid=0, inst=16'h0000, inst_valid=0, inst_pc=0, imem_req=0.
- First request is in the cycle after reset deassertion plus one edge (IDLE→FETCH).
- Zero-wait memory (imem_valid always high): one instruction per cycle. Latency is one cycle from imem_valid to inst/inst_valid.
- Redirect in cycle n with imem_valid high: imem_addr=redirect_pc in cycle n+1; the target instruction appears in cycle n+2.
- Stall asserted with a response arriving: the response is never lost. After stall drops, it is presented one edge later.
- No combinational path from stall or redirect to imem_addr; imem_req is a function of state only.

## Structure
- Shared package cpu_pkg holds: fetch_state_t enum (IDLE, FETCH, HOLD, DRAIN), INST_W=16, and BUBBLE_INST=16'h0000.
- Single module; skid buffer and FSM are inline. No sub-module.

## Test plan
- Reset release, zero-wait memory returning 16'h5A00+addr: inst_pc 0,1,2,3 on consecutive cycles, inst 16'h5A00..16'h5A03, imem_req=0 in the first post-reset cycle.
- Stall high for 3 cycles while word 16'h1234 at addr 5 returns: inst holds its prior value. One edge after stall drops, inst=16'h1234, inst_pc=5, and the next request is addr 6.
- Redirect to 16'h0040 with imem_valid high: the in-flight word is discarded, inst_valid=0 next cycle, and imem_addr=16'h0040.
- Memory with 3-cycle latency, redirect to 16'h0080 in the first wait cycle, then a second redirect to 16'h0090: imem_addr holds the old address until imem_valid, the word is dropped, and the next request is 16'h0090.
- pc=16'hFFFF fetched: pc_plus1=16'h0000 and the next request address is 16'h0000.
- rst_n pulsed low while in HOLD with skid loaded: all outputs return to reset values immediately, and fetch restarts at RESET_PC.
